// File: rtl/kl8_pkg.sv
// Shared definitions for the KL8 console controllers.
// State encoding, IOP bit positions and device codes.
package kl8_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_P1,
        ST_G1,
        ST_P2,
        ST_G2,
        ST_P4,
        ST_DONE
    } kl8_state_e;

    localparam int OP_SKP = 0;
    localparam int OP_CLR = 1;
    localparam int OP_RD  = 2;

    localparam logic [5:0] DEV_KBD = 6'o03;
    localparam logic [5:0] DEV_TTO = 6'o04;

endpackage

// File: rtl/baud_tick_gen.sv
// Free-running 8x-baud tick: one-cycle pulse every DIV clocks while enabled.
// Shared by the keyboard and teleprinter controllers.
module baud_tick_gen #(
    parameter int DIV = 1136
) (
    input  logic clk,
    input  logic rst_n,
    input  logic en,
    output logic tick
);

    localparam int W = $clog2(DIV);
    localparam logic [W-1:0] LAST = W'(DIV - 1);

    logic [W-1:0] cnt_q, cnt_d;
    logic         tick_q;

    always_comb begin
        cnt_d = '0;
        if (en) begin
            cnt_d = (cnt_q == LAST) ? '0 : cnt_q + 1'b1;
        end
    end

    // Tick is registered alongside the count, so it is high exactly while cnt_q==LAST.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q  <= '0;
            tick_q <= 1'b0;
        end else begin
            cnt_q  <= cnt_d;
            tick_q <= en && (cnt_d == LAST);
        end
    end

    assign tick = tick_q;

endmodule

// File: rtl/kl8_kbd_ctl.sv
// KL8 keyboard/reader IOT sequencer: timed IOP1/IOP2/IOP4 strobes,
// skip/data return, reader-run handshake and baud tick.
module kl8_kbd_ctl
    import kl8_pkg::*;
#(
    parameter logic [5:0] DEV      = DEV_KBD,
    parameter int         IOP_W    = 4,
    parameter int         GAP_W    = 2,
    parameter int         BAUD_DIV = 1136,
    parameter int         RUN_TO   = 65535
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       iot_valid,
    input  logic [5:0] iot_dev,
    input  logic [2:0] iot_op,
    input  logic       io_clr,
    input  logic       baud_en,
    input  logic       rx_flag,
    input  logic       rx_active,
    input  logic [7:0] rx_data,
    output logic       busy,
    output logic       iot_done,
    output logic       skip,
    output logic       ac_clr,
    output logic [7:0] data_out,
    output logic       data_valid,
    output logic       skp_strobe,
    output logic       clr_flag,
    output logic       read_buf,
    output logic       reader_run,
    output logic       baud_tick
);

    localparam int PW = (IOP_W > GAP_W) ? IOP_W : GAP_W;
    localparam int CW = ($clog2(PW) > 0) ? $clog2(PW) : 1;
    localparam int TW = $clog2(RUN_TO + 1);

    localparam logic [CW-1:0] IOP_LAST = CW'(IOP_W - 1);
    localparam logic [CW-1:0] GAP_LAST = CW'(GAP_W - 1);
    localparam logic [TW-1:0] TMR_INIT = TW'(RUN_TO);
    localparam logic [TW-1:0] TMR_ONE  = TW'(1);

    kl8_state_e    state_q;
    logic [CW-1:0] cnt_q;
    logic [2:0]    op_q;
    logic          skp_q, clr_q, rd_q;
    logic          done_q, skip_q, acclr_q, dv_q;
    logic [7:0]    data_q;
    logic          run_q;
    logic [TW-1:0] timer_q;
    logic          act_q;

    logic          run_set_d;
    logic          act_rise_d;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
            op_q    <= '0;
            skp_q   <= 1'b0;
            clr_q   <= 1'b0;
            rd_q    <= 1'b0;
            done_q  <= 1'b0;
            skip_q  <= 1'b0;
            acclr_q <= 1'b0;
            dv_q    <= 1'b0;
            data_q  <= '0;
        end else if (io_clr) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
            op_q    <= '0;
            skp_q   <= 1'b0;
            clr_q   <= 1'b0;
            rd_q    <= 1'b0;
            done_q  <= 1'b0;
            skip_q  <= 1'b0;
            acclr_q <= 1'b0;
            dv_q    <= 1'b0;
            data_q  <= '0;
        end else begin
            done_q <= 1'b0;
            unique case (state_q)
                ST_IDLE: begin
                    if (iot_valid && (iot_dev == DEV)) begin
                        op_q    <= iot_op;
                        cnt_q   <= '0;
                        skp_q   <= iot_op[OP_SKP];
                        state_q <= ST_P1;
                    end
                end
                ST_P1: begin
                    if (cnt_q == IOP_LAST) begin
                        skip_q  <= op_q[OP_SKP] & rx_flag;
                        skp_q   <= 1'b0;
                        cnt_q   <= '0;
                        state_q <= ST_G1;
                    end else begin
                        cnt_q <= cnt_q + 1'b1;
                    end
                end
                ST_G1: begin
                    if (cnt_q == GAP_LAST) begin
                        clr_q   <= op_q[OP_CLR];
                        cnt_q   <= '0;
                        state_q <= ST_P2;
                    end else begin
                        cnt_q <= cnt_q + 1'b1;
                    end
                end
                ST_P2: begin
                    if (cnt_q == IOP_LAST) begin
                        acclr_q <= op_q[OP_CLR];
                        clr_q   <= 1'b0;
                        cnt_q   <= '0;
                        state_q <= ST_G2;
                    end else begin
                        cnt_q <= cnt_q + 1'b1;
                    end
                end
                ST_G2: begin
                    if (cnt_q == GAP_LAST) begin
                        rd_q    <= op_q[OP_RD];
                        cnt_q   <= '0;
                        state_q <= ST_P4;
                    end else begin
                        cnt_q <= cnt_q + 1'b1;
                    end
                end
                ST_P4: begin
                    if (cnt_q == IOP_LAST) begin
                        if (op_q[OP_RD]) begin
                            data_q <= rx_data;
                            dv_q   <= 1'b1;
                        end
                        rd_q    <= 1'b0;
                        cnt_q   <= '0;
                        done_q  <= 1'b1;
                        state_q <= ST_DONE;
                    end else begin
                        cnt_q <= cnt_q + 1'b1;
                    end
                end
                ST_DONE: begin
                    skip_q  <= 1'b0;
                    acclr_q <= 1'b0;
                    dv_q    <= 1'b0;
                    state_q <= ST_IDLE;
                end
                default: state_q <= ST_IDLE;
            endcase
        end
    end

    assign run_set_d = (state_q == ST_P2) && (cnt_q == IOP_LAST)
                     && op_q[OP_CLR];
    assign act_rise_d = rx_active & ~act_q;

    // A KCC landing with a clear event restarts the run rather than stopping it.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            run_q   <= 1'b0;
            timer_q <= '0;
            act_q   <= 1'b0;
        end else begin
            act_q <= rx_active;
            if (io_clr) begin
                run_q   <= 1'b0;
                timer_q <= '0;
            end else if (run_set_d) begin
                run_q   <= 1'b1;
                timer_q <= TMR_INIT;
            end else if (run_q && (act_rise_d || timer_q == TMR_ONE)) begin
                run_q   <= 1'b0;
                timer_q <= '0;
            end else if (run_q) begin
                timer_q <= timer_q - 1'b1;
            end
        end
    end

    baud_tick_gen #(
        .DIV(BAUD_DIV)
    ) u_baud (
        .clk  (clk),
        .rst_n(rst_n),
        .en   (baud_en),
        .tick (baud_tick)
    );

    assign busy       = (state_q != ST_IDLE);
    assign iot_done   = done_q;
    assign skip       = done_q & skip_q;
    assign ac_clr     = done_q & acclr_q;
    assign data_valid = done_q & dv_q;
    assign data_out   = data_q;
    assign skp_strobe = skp_q;
    assign clr_flag   = clr_q;
    assign read_buf   = rd_q;
    assign reader_run = run_q;

endmodule
